// File: rtl/sme_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sme_engine
//  Description : Byte-serial string-matching engine. Holds a target string of
//                up to 32 characters and searches it for patterns of up to 8
//                characters. Supports '.', '^', '$' and a single '*'.
//                Reports match and the leftmost match index.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                chardata[7:0]     - character input
//                isstring          - string character strobe
//                ispattern         - pattern character strobe
//                valid             - one-cycle result strobe
//                match             - pattern found
//                match_index[4:0]  - leftmost match start (0 when no match)
//  Revision    : 1.0 - initial release
// ============================================================================
module sme_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] chardata,
    input  logic       isstring,
    input  logic       ispattern,
    output logic       valid,
    output logic       match,
    output logic [4:0] match_index
);

    localparam logic [7:0] c_SPACE  = 8'h20;
    localparam logic [7:0] c_DOT    = 8'h2E;
    localparam logic [7:0] c_CARET  = 8'h5E;
    localparam logic [7:0] c_DOLLAR = 8'h24;
    localparam logic [7:0] c_STAR   = 8'h2A;
    localparam logic [5:0] c_LAST_CURSOR = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_STR = 3'd1,
        S_LOAD_PAT = 3'd2,
        S_SEARCH   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_str [0:31];
    logic [5:0]  r_str_len;
    logic [7:0]  r_pat [0:7];
    logic [3:0]  r_pat_len;
    logic [5:0]  r_cursor;
    // Bit p set when the prefix / suffix segment matches with its cursor at p.
    logic [32:0] r_pre_vec;
    logic [32:0] r_suf_vec;

    // Pattern decomposition around the optional '*':
    // prefix = [0, w_star_idx), suffix = [w_suf_lo, r_pat_len).
    // Without a star the suffix is empty and matches at any cursor <= length.
    logic        w_has_star;
    logic [3:0]  w_star_idx;
    logic [3:0]  w_suf_lo;
    logic [3:0]  w_pre_cons;
    logic [3:0]  w_suf_cons;
    logic        w_pre_ok;
    logic        w_suf_ok;

    logic        w_has_pre;
    logic [5:0]  w_min_pre;
    logic        w_has_suf;
    logic [5:0]  w_max_suf;
    logic        w_found;
    logic [5:0]  w_found_idx;

    function automatic logic [7:0] str_at(input logic [5:0] pos);
        return (pos < 6'd32) ? r_str[pos[4:0]] : 8'h00;
    endfunction

    function automatic logic is_consuming(input logic [7:0] c);
        return (c != c_CARET) && (c != c_DOLLAR) && (c != c_STAR);
    endfunction

    // Match pattern elements [lo,hi) with the cursor starting between
    // characters at position cur. Zero-width elements do not advance it.
    function automatic logic seg_match(input logic [5:0] cur,
                                       input logic [3:0] lo,
                                       input logic [3:0] hi);
        logic       ok;
        logic [5:0] pos;
        logic [7:0] c;
        ok  = (cur <= r_str_len);
        pos = cur;
        for (int k = 0; k < 8; k++) begin
            if (k >= int'(lo) && k < int'(hi)) begin
                c = r_pat[k];
                if (c == c_CARET) begin
                    ok = ok && ((pos == 6'd0) || (str_at(pos - 6'd1) == c_SPACE));
                end else if (c == c_DOLLAR) begin
                    ok = ok && ((pos == r_str_len) ||
                                ((pos < r_str_len) && (str_at(pos) == c_SPACE)));
                end else begin
                    ok  = ok && (pos < r_str_len) && ((c == c_DOT) || (str_at(pos) == c));
                    pos = pos + 6'd1;
                end
            end
        end
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Pattern analysis
    // ------------------------------------------------------------------
    always_comb begin
        w_has_star = 1'b0;
        w_star_idx = r_pat_len;
        for (int k = 0; k < 8; k++) begin
            if ((4'(k) < r_pat_len) && (r_pat[k] == c_STAR) && !w_has_star) begin
                w_has_star = 1'b1;
                w_star_idx = 4'(k);
            end
        end
        w_suf_lo   = w_has_star ? (w_star_idx + 4'd1) : r_pat_len;
        w_pre_cons = 4'd0;
        w_suf_cons = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (is_consuming(r_pat[k])) begin
                if (4'(k) < w_star_idx) begin
                    w_pre_cons = w_pre_cons + 4'd1;
                end else if ((4'(k) >= w_suf_lo) && (4'(k) < r_pat_len)) begin
                    w_suf_cons = w_suf_cons + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_pre_ok = seg_match(r_cursor, 4'd0, w_star_idx);
        w_suf_ok = seg_match(r_cursor, w_suf_lo, r_pat_len);
    end

    // ------------------------------------------------------------------
    // Result resolution. The reported index is the prefix cursor when the
    // prefix holds a consuming character (or nothing consumes at all);
    // otherwise it is the suffix cursor, i.e. the first character after '*'.
    // Descending scans leave the smallest qualifying index in place.
    // ------------------------------------------------------------------
    always_comb begin
        w_has_pre   = 1'b0;
        w_min_pre   = 6'd0;
        w_has_suf   = 1'b0;
        w_max_suf   = 6'd0;
        w_found     = 1'b0;
        w_found_idx = 6'd0;
        for (int i = 32; i >= 0; i--) begin
            if (r_pre_vec[i]) begin
                w_has_pre = 1'b1;
                w_min_pre = 6'(i);
            end
        end
        for (int i = 0; i <= 32; i++) begin
            if (r_suf_vec[i]) begin
                w_has_suf = 1'b1;
                w_max_suf = 6'(i);
            end
        end
        if ((w_pre_cons != 4'd0) || (w_suf_cons == 4'd0)) begin
            for (int i = 32; i >= 0; i--) begin
                if (r_pre_vec[i] && w_has_suf &&
                    ((7'(i) + {3'b000, w_pre_cons}) <= {1'b0, w_max_suf})) begin
                    w_found     = 1'b1;
                    w_found_idx = 6'(i);
                end
            end
        end else begin
            for (int i = 32; i >= 0; i--) begin
                if (r_suf_vec[i] && w_has_pre && (6'(i) >= w_min_pre)) begin
                    w_found     = 1'b1;
                    w_found_idx = 6'(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        valid        = 1'b0;
        match        = 1'b0;
        match_index  = 5'd0;
        case (r_state)
            S_IDLE: begin
                if (isstring) begin
                    w_next_state = S_LOAD_STR;
                end else if (ispattern) begin
                    w_next_state = S_LOAD_PAT;
                end
            end
            S_LOAD_STR: begin
                if (ispattern) begin
                    w_next_state = S_LOAD_PAT;
                end else if (!isstring) begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD_PAT: begin
                if (!ispattern) begin
                    w_next_state = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (r_cursor == c_LAST_CURSOR) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                valid        = 1'b1;
                match        = w_found;
                match_index  = w_found ? w_found_idx[4:0] : 5'd0;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: character storage and search scan
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_str[i] <= 8'h00;
            end
            for (int i = 0; i < 8; i++) begin
                r_pat[i] <= 8'h00;
            end
            r_str_len <= 6'd0;
            r_pat_len <= 4'd0;
            r_cursor  <= 6'd0;
            r_pre_vec <= '0;
            r_suf_vec <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD_STR: begin
                    if (isstring) begin
                        if (r_state == S_IDLE) begin
                            // New burst: discard the previous string entirely.
                            for (int i = 1; i < 32; i++) begin
                                r_str[i] <= 8'h00;
                            end
                            r_str[0]  <= chardata;
                            r_str_len <= 6'd1;
                        end else if (r_str_len < 6'd32) begin
                            r_str[r_str_len[4:0]] <= chardata;
                            r_str_len             <= r_str_len + 6'd1;
                        end
                    end else if (ispattern) begin
                        for (int i = 1; i < 8; i++) begin
                            r_pat[i] <= 8'h00;
                        end
                        r_pat[0]  <= chardata;
                        r_pat_len <= 4'd1;
                    end
                end
                S_LOAD_PAT: begin
                    if (ispattern) begin
                        if (r_pat_len < 4'd8) begin
                            r_pat[r_pat_len[2:0]] <= chardata;
                            r_pat_len             <= r_pat_len + 4'd1;
                        end
                    end else begin
                        r_cursor  <= 6'd0;
                        r_pre_vec <= '0;
                        r_suf_vec <= '0;
                    end
                end
                S_SEARCH: begin
                    r_pre_vec[r_cursor] <= w_pre_ok;
                    r_suf_vec[r_cursor] <= w_suf_ok;
                    r_cursor            <= r_cursor + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sme_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sme_engine
//  Description : Self-checking bench for sme_engine. Table of string/pattern
//                vectors with expected results pushed to a scoreboard queue
//                and compared when the result strobe appears, plus reset
//                corner-case sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sme_engine;

    logic       clk;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    bit prev_valid = 1'b0;

    sme_engine dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           reload;
        logic [255:0] s;
        int           slen;
        logic [63:0]  p;
        int           plen;
        bit           m;
        int           idx;
    } vec_t;

    typedef struct {
        bit         m;
        logic [4:0] idx;
        int         id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t vt[$];

    function automatic vec_t mk(input bit rl, input string s, input string p,
                                input bit m, input int idx);
        vec_t v;
        v.reload = rl;
        v.s      = '0;
        v.p      = '0;
        v.slen   = s.len();
        v.plen   = p.len();
        for (int i = 0; i < s.len(); i++) v.s[8*i +: 8] = s[i];
        for (int i = 0; i < p.len(); i++) v.p[8*i +: 8] = p[i];
        v.m   = m;
        v.idx = idx;
        return v;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_width: valid high %0d cycles in a row, required 1", 2);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got strobe match=%0d idx=%0d, required no strobe",
                         match, match_index);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (match !== e.m) begin
                    errors++;
                    $display("FAIL match[vec %0d]: got %0d, required %0d", e.id, match, e.m);
                end
                if (match_index !== e.idx) begin
                    errors++;
                    $display("FAIL match_index[vec %0d]: got %0d, required %0d",
                             e.id, match_index, e.idx);
                end
            end
        end
        prev_valid = valid;
    end

    task automatic send_bytes(input logic [255:0] d, input int n, input bit is_str);
        for (int i = 0; i < n; i++) begin
            chardata  = d[8*i +: 8];
            isstring  = is_str;
            ispattern = !is_str;
            @(posedge clk); #1;
        end
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = 8'h00;
    endtask

    // Wait (bounded) for the result strobe of the pattern just sent.
    task automatic wait_result(input int id);
        int n;
        int start;
        n     = 0;
        start = n_valid;
        while ((n_valid == start) && (n < 81)) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n_valid == start) begin
            errors++;
            $display("FAIL latency[vec %0d]: got no valid in %0d cycles, required <= 80", id, n);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        exp_t x;
        if (v.reload) send_bytes(v.s, v.slen, 1'b1);
        send_bytes({192'b0, v.p}, v.plen, 1'b0);
        x.m   = v.m;
        x.idx = 5'(v.idx);
        x.id  = id;
        sb.push_back(x);
        wait_result(id);
    endtask

    task automatic check_outputs_zero(input string name);
        @(negedge clk);
        checks += 3;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid: got %0d, required 0", name, valid);
        end
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL %s match: got %0d, required 0", name, match);
        end
        if (match_index !== 5'd0) begin
            errors++;
            $display("FAIL %s match_index: got %0d, required 0", name, match_index);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        string s32;
        int    base;

        s32 = "";
        for (int i = 0; i < 31; i++) s32 = {s32, "a"};
        s32 = {s32, "b"};

        vt.push_back(mk(1, "hello world", "wor",  1, 6));
        vt.push_back(mk(0, "",            "^wor", 1, 6));
        vt.push_back(mk(0, "",            "llo$", 1, 2));
        vt.push_back(mk(0, "",            "d$",   1, 10));
        vt.push_back(mk(0, "",            "^h",   1, 0));
        vt.push_back(mk(0, "",            "o.w",  1, 4));
        vt.push_back(mk(0, "",            "l*d",  1, 2));
        vt.push_back(mk(0, "",            "xyz",  0, 0));
        vt.push_back(mk(0, "",            "hel$", 0, 0));
        vt.push_back(mk(0, "",            "^o",   0, 0));
        vt.push_back(mk(0, "",            "*d",   1, 10));
        vt.push_back(mk(0, "",            "$",    1, 5));
        vt.push_back(mk(0, "",            "w*o",  1, 6));
        vt.push_back(mk(1, s32,           "ab$",  1, 30));
        vt.push_back(mk(0, "",            "b",    1, 31));
        vt.push_back(mk(0, "",            "a$",   0, 0));
        vt.push_back(mk(1, "abc",         "wor",  0, 0));
        vt.push_back(mk(0, "",            "c$",   1, 2));
        vt.push_back(mk(0, "",            "^",    1, 0));
        vt.push_back(mk(0, "",            "d",    0, 0));

        reset     = 1'b1;
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) begin
            run_vec(vt[i], i);
        end

        // Reset in the middle of a pattern load: no strobe may follow.
        send_bytes(mk(0, "xyz abc", "", 0, 0).s, 7, 1'b1);
        chardata  = "a";
        ispattern = 1'b1;
        @(posedge clk); #1;
        chardata  = "b";
        reset     = 1'b1;
        @(posedge clk); #1;
        ispattern = 1'b0;
        chardata  = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        base  = n_valid;
        repeat (90) @(posedge clk);
        #1;
        checks++;
        if (n_valid != base) begin
            errors++;
            $display("FAIL aborted_load: got %0d strobes, required 0", n_valid - base);
        end
        check_outputs_zero("post_abort");

        run_vec(mk(1, "foo bar", "bar",    1, 4), 100);
        run_vec(mk(0, "",        "^b.r$",  1, 4), 101);
        run_vec(mk(0, "",        "abc",    0, 0), 102);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
